wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 64, data width of a register-file write.
REQ-002 SHALL have parameter NREG, default 32, number of architectural registers (index width 5).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports a_valid/a_ready  input/output  1/1  ALU write-back handshake.
REQ-006 SHALL have ports a_rd/a_data  input  5/XLEN  ALU destination index and result.
REQ-007 SHALL have ports b_valid/b_ready  input/output  1/1  load-unit write-back handshake.
REQ-008 SHALL have ports b_rd/b_data  input  5/XLEN  load destination index and data.
REQ-009 SHALL have ports reg_write/rd/write_data  output  1/5/XLEN  registered drive of the register-file write port.
REQ-010 SHALL have ports issue_valid/issue_ready/issue_rd  input/output/input  1/1/5  decode reserves a destination register.
REQ-011 SHALL have ports rs1/rs2  input  5/5  and rs1_busy/rs2_busy  output  1/1  source-operand hazard query.

Function
REQ-012 SHALL transfer on a requester when valid && ready in the same cycle; ready SHALL be a combinational function of both valids and the priority pointer only.
REQ-013 SHALL grant at most one requester per cycle; a sole valid requester SHALL be granted that cycle.
REQ-014 SHALL, with both valid, grant the requester indicated by the priority pointer; pointer SHALL move to the other requester after each granted transfer (round-robin).
REQ-015 SHALL register a granted transfer: reg_write/rd/write_data valid exactly one cycle after the handshake cycle, reg_write high for one cycle per transfer.
REQ-016 SHALL accept a transfer with rd = 0 (ready asserted normally) but keep reg_write low for it and not touch the scoreboard.
REQ-017 SHALL hold a 32-bit busy vector; bit 0 SHALL read 0 permanently.
REQ-018 SHALL set busy[issue_rd] at the clock edge where issue_valid && issue_ready && issue_rd != 0.
REQ-019 SHALL clear busy[rd] at the clock edge on which registered reg_write is high for that rd.
REQ-020 SHALL, when set and clear of the same index coincide, leave the bit set.
REQ-021 SHALL drive issue_ready = (issue_rd == 0) || !busy[issue_rd], combinational; a register clearing this cycle SHALL still report busy (no bypass).
REQ-022 SHALL drive rs1_busy = busy[rs1], rs2_busy = busy[rs2], combinational, 0 for index 0.
REQ-023 SHALL leave a_ready/b_ready low when the respective valid is low.
REQ-024 SHALL not depend on issue activity for arbitration; write-back and issue proceed concurrently.

Reset
REQ-025 SHALL, while reset is high at a clock edge, clear busy vector, set pointer to requester A, drive reg_write = 0, rd = 0, write_data = 0.
REQ-026 SHALL discard any handshake occurring in a reset cycle; ready outputs SHALL be 0 while reset is high.
REQ-027 SHALL resume normal arbitration on the first edge after reset deasserts, pointer at A.

Structure
REQ-028 SHALL take XLEN, REG_IDX_W = 5, NREG = 32 from the shared core package.
REQ-029 SHALL implement the two-way round-robin grant and pointer in one sub-module rr_arb2; scoreboard and output register live in wb_arbiter.

Verification
REQ-030 SHALL cover: a_valid only, a_rd = 5, a_data = 0x11 -> a_ready same cycle; next cycle reg_write = 1, rd = 5, write_data = 0x11.
REQ-031 SHALL cover: a and b valid for 4 cycles after reset (rd 1/2) -> grants A,B,A,B; reg_write 4 consecutive cycles.
REQ-032 SHALL cover: issue rd = 7, then issue rd = 7 again -> second issue_ready = 0, rs1 = 7 busy = 1 until write-back of rd 7 retires; cleared one edge later.
REQ-033 SHALL cover: issue rd = 3 in same edge as reg_write for rd = 3 -> busy[3] remains 1.
REQ-034 SHALL cover: b_valid, b_rd = 0 -> b_ready = 1, reg_write stays 0, busy unchanged.
REQ-035 SHALL cover: reset asserted mid-stream with busy bits set and a transfer pending -> next cycle all busy = 0, reg_write = 0, pointer at A.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared core constants and types for the write-back arbiter: register-file
// geometry, the round-robin pointer encoding and a one-hot index helper.
package wb_arbiter_pkg;

    localparam int XLEN      = 64;
    localparam int REG_IDX_W = 5;
    localparam int NREG      = 32;

    typedef enum logic {
        PTR_A = 1'b0,
        PTR_B = 1'b1
    } ptr_e;

    function automatic logic [NREG-1:0] idx_onehot(input logic [REG_IDX_W-1:0] idx);
        return {{(NREG-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant from the two requests and
// the priority pointer; the pointer flips to the other side after every grant.
module rr_arb2
    import wb_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    ptr_e ptr_r;
    ptr_e ptr_next_s;

    // Priority pointer register, parked at A by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r <= PTR_A;
        end else begin
            ptr_r <= ptr_next_s;
        end
    end

    // Grant selection and pointer advance; no grant while in reset.
    always_comb begin
        gnt_a      = 1'b0;
        gnt_b      = 1'b0;
        ptr_next_s = ptr_r;
        if (reset) begin
            gnt_a = 1'b0;
            gnt_b = 1'b0;
        end else if (req_a && req_b) begin
            case (ptr_r)
                PTR_A:   gnt_a = 1'b1;
                PTR_B:   gnt_b = 1'b1;
                default: gnt_a = 1'b1;
            endcase
        end else if (req_a) begin
            gnt_a = 1'b1;
        end else if (req_b) begin
            gnt_b = 1'b1;
        end else begin
            gnt_a = 1'b0;
            gnt_b = 1'b0;
        end

        if (gnt_a) begin
            ptr_next_s = PTR_B;
        end else if (gnt_b) begin
            ptr_next_s = PTR_A;
        end else begin
            ptr_next_s = ptr_r;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU and load write-backs onto one registered
// register-file write port and tracks pending destinations in a busy scoreboard.
module wb_arbiter #(
    parameter int XLEN = wb_arbiter_pkg::XLEN,
    parameter int NREG = wb_arbiter_pkg::NREG
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                a_valid,
    output logic                                a_ready,
    input  logic [wb_arbiter_pkg::REG_IDX_W-1:0] a_rd,
    input  logic [XLEN-1:0]                     a_data,
    input  logic                                b_valid,
    output logic                                b_ready,
    input  logic [wb_arbiter_pkg::REG_IDX_W-1:0] b_rd,
    input  logic [XLEN-1:0]                     b_data,
    output logic                                reg_write,
    output logic [wb_arbiter_pkg::REG_IDX_W-1:0] rd,
    output logic [XLEN-1:0]                     write_data,
    input  logic                                issue_valid,
    output logic                                issue_ready,
    input  logic [wb_arbiter_pkg::REG_IDX_W-1:0] issue_rd,
    input  logic [wb_arbiter_pkg::REG_IDX_W-1:0] rs1,
    input  logic [wb_arbiter_pkg::REG_IDX_W-1:0] rs2,
    output logic                                rs1_busy,
    output logic                                rs2_busy
);

    import wb_arbiter_pkg::*;

    logic                 gnt_a_s;
    logic                 gnt_b_s;
    logic                 wr_en_s;
    logic [REG_IDX_W-1:0] sel_rd_s;
    logic [XLEN-1:0]      sel_data_s;
    logic                 issue_fire_s;
    logic [NREG-1:0]      clr_mask_s;
    logic [NREG-1:0]      set_mask_s;
    logic [NREG-1:0]      busy_next_s;
    logic [NREG-1:0]      busy_r;
    logic                 reg_write_r;
    logic [REG_IDX_W-1:0] rd_r;
    logic [XLEN-1:0]      write_data_r;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req_a (a_valid),
        .req_b (b_valid),
        .gnt_a (gnt_a_s),
        .gnt_b (gnt_b_s)
    );

    assign a_ready = gnt_a_s;
    assign b_ready = gnt_b_s;

    // Route the granted requester; writes to x0 are accepted but dropped.
    always_comb begin
        sel_rd_s   = a_rd;
        sel_data_s = a_data;
        if (gnt_b_s) begin
            sel_rd_s   = b_rd;
            sel_data_s = b_data;
        end else begin
            sel_rd_s   = a_rd;
            sel_data_s = a_data;
        end
        wr_en_s = (gnt_a_s || gnt_b_s) && (sel_rd_s != {REG_IDX_W{1'b0}});
    end

    // Registered register-file write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_r  <= 1'b0;
            rd_r         <= {REG_IDX_W{1'b0}};
            write_data_r <= {XLEN{1'b0}};
        end else begin
            reg_write_r <= wr_en_s;
            if (wr_en_s) begin
                rd_r         <= sel_rd_s;
                write_data_r <= sel_data_s;
            end
        end
    end

    assign reg_write  = reg_write_r;
    assign rd         = rd_r;
    assign write_data = write_data_r;

    // No bypass: a register retiring this cycle still blocks a new issue.
    assign issue_ready  = (issue_rd == {REG_IDX_W{1'b0}}) || !busy_r[issue_rd];
    assign issue_fire_s = issue_valid && issue_ready && (issue_rd != {REG_IDX_W{1'b0}});

    // Scoreboard next state: retire clears first, a same-index issue wins.
    always_comb begin
        clr_mask_s     = reg_write_r  ? NREG'(idx_onehot(rd_r))     : {NREG{1'b0}};
        set_mask_s     = issue_fire_s ? NREG'(idx_onehot(issue_rd)) : {NREG{1'b0}};
        busy_next_s    = (busy_r & ~clr_mask_s) | set_mask_s;
        busy_next_s[0] = 1'b0;
    end

    // Busy scoreboard register.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busy_next_s;
        end
    end

    assign rs1_busy = busy_r[rs1];
    assign rs2_busy = busy_r[rs2];

endmodule
